// File: rtl/pc_register.sv
// Instruction-fetch program counter with sequential increment
// and a valid flag that drops while the PC is held in reset.
`timescale 1ns/1ps
module pc_register #(
   parameter int unsigned RegWidth = 16,
   parameter logic [RegWidth-1:0] RESET_VALUE = '0,
   parameter logic [RegWidth-1:0] PC_INC = RegWidth'(1)
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic [RegWidth-1:0] PC_In,
   output logic [RegWidth-1:0] PC_Out,
   output logic [RegWidth-1:0] PC_Plus,
   output logic                PC_Valid
);

   // Stalls are built upstream by recirculating PC_Out into PC_In.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         PC_Out   <= RESET_VALUE;
         PC_Valid <= 1'b0;
      end else begin
         PC_Out   <= PC_In;
         PC_Valid <= 1'b1;
      end
   end

   assign PC_Plus = PC_Out + PC_INC;

endmodule

// File: tb/tb_pc_register.sv
// Directed checks of pc_register: reset behaviour, load latency,
// wrap-around of PC_Plus, hold by feedback, non-default parameters.
`timescale 1ns/1ps
module tb_pc_register;

   logic        CLK;
   logic        RST;
   logic [15:0] PC_In;
   logic [15:0] PC_Out;
   logic [15:0] PC_Plus;
   logic        PC_Valid;
   logic [7:0]  pc_out8;
   logic [7:0]  pc_plus8;
   logic        pc_valid8;

   int n_chk;
   int n_pass;

   pc_register u_dut (
      .CLK      (CLK),
      .RST      (RST),
      .PC_In    (PC_In),
      .PC_Out   (PC_Out),
      .PC_Plus  (PC_Plus),
      .PC_Valid (PC_Valid)
   );

   pc_register #(
      .RegWidth    (8),
      .RESET_VALUE (8'hF0),
      .PC_INC      (8'h04)
   ) u_dut8 (
      .CLK      (CLK),
      .RST      (RST),
      .PC_In    (PC_In[7:0]),
      .PC_Out   (pc_out8),
      .PC_Plus  (pc_plus8),
      .PC_Valid (pc_valid8)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic check(input string tag,
                        input logic [15:0] got,
                        input logic [15:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t",
                    tag, got, exp, $time);
   endtask

   task automatic check_main(input string tag,
                             input logic [15:0] pc,
                             input logic [15:0] plus,
                             input logic vld);
      check({tag, ".pc"}, PC_Out, pc);
      check({tag, ".plus"}, PC_Plus, plus);
      check({tag, ".vld"}, {15'd0, PC_Valid}, {15'd0, vld});
   endtask

   task automatic check_w8(input string tag,
                           input logic [7:0] pc,
                           input logic [7:0] plus,
                           input logic vld);
      check({tag, ".pc8"}, {8'd0, pc_out8}, {8'd0, pc});
      check({tag, ".plus8"}, {8'd0, pc_plus8}, {8'd0, plus});
      check({tag, ".vld8"}, {15'd0, pc_valid8}, {15'd0, vld});
   endtask

   initial begin
      n_chk  = 0;
      n_pass = 0;
      RST    = 1'b0;
      PC_In  = 16'd0;

      #7;   // t=7, after edge at 5
      check_main("por_a", 16'd0, 16'd1, 1'b0);
      check_w8("por_a", 8'hF0, 8'hF4, 1'b0);
      #3;   // t=10
      PC_In = 16'd59;
      #7;   // t=17, edge at 15 must not load
      check_main("por_b", 16'd0, 16'd1, 1'b0);
      #3;   // t=20
      RST = 1'b1;
      #2;   // t=22, release waits for an edge
      check_main("rel_wait", 16'd0, 16'd1, 1'b0);
      #4;   // t=26, after edge at 25
      check_main("load59", 16'd59, 16'd60, 1'b1);
      check_w8("load59", 8'h3B, 8'h3F, 1'b1);
      #4;   // t=30
      RST   = 1'b0;
      PC_In = 16'd93;
      #1;   // t=31, mid-cycle reset
      check_main("async_rst", 16'd0, 16'd1, 1'b0);
      check_w8("async_rst", 8'hF0, 8'hF4, 1'b0);
      #6;   // t=37
      check_main("rst_hold", 16'd0, 16'd1, 1'b0);
      #3;   // t=40
      RST = 1'b1;
      #2;   // t=42
      check_main("rel2_wait", 16'd0, 16'd1, 1'b0);
      #4;   // t=46
      check_main("load93", 16'd93, 16'd94, 1'b1);
      #4;   // t=50
      PC_In = 16'hFFFF;
      #6;   // t=56
      check_main("wrap", 16'hFFFF, 16'h0000, 1'b1);
      check_w8("wrap", 8'hFF, 8'h03, 1'b1);

      PC_In = PC_Out;
      for (int i = 0; i < 3; i++) begin
         @(posedge CLK);
         #1;
         check_main($sformatf("hold%0d", i),
                    16'hFFFF, 16'h0000, 1'b1);
         PC_In = PC_Out;
      end

      PC_In = 16'd7;
      @(posedge CLK);
      RST = 1'b0;
      #1;
      check_main("edge_rst", 16'd0, 16'd1, 1'b0);
      check_w8("edge_rst", 8'hF0, 8'hF4, 1'b0);

      #3;
      RST   = 1'b1;
      PC_In = 16'h1234;
      @(posedge CLK);
      #1;
      check_main("verbatim", 16'h1234, 16'h1235, 1'b1);
      check_w8("verbatim", 8'h34, 8'h38, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/pc_register.md
# pc_register

Program-counter register for the instruction-fetch (IF) stage of the pipelined processor. It holds the address of the instruction currently being fetched and loads the next PC (computed upstream by the PC-select logic) on every rising clock edge. It also provides a sequential-increment output and a valid flag, which downstream fetch logic uses to suppress fetches while the PC is in reset.

## Interface

Parameters:
- RegWidth, default 16: width of the PC in bits.
- RESET_VALUE, default 0: PC value forced during reset; RegWidth bits wide.
- PC_INC, default 1: increment applied to form PC_Plus (word-addressed instruction memory).

Ports:
- CLK, input, 1: the block's single clock; all state updates occur on its rising edge.
- RST, input, 1: reset, asynchronous and active-low.
- PC_In, input, RegWidth: next PC value, loaded on each rising CLK edge when not in reset.
- PC_Out, output, RegWidth: current PC, registered.
- PC_Plus, output, RegWidth: combinational PC_Out + PC_INC, truncated modulo 2^RegWidth.
- PC_Valid, output, 1: registered flag; 0 in reset, 1 from the first load after reset release.

## Operation

- RST = 0: PC_Out = RESET_VALUE and PC_Valid = 0, immediately, without waiting for a clock edge.
  - Held for as long as RST stays low; PC_In is ignored.
- RST = 1: on every rising CLK edge, PC_Out <= PC_In and PC_Valid <= 1.
  - There is no enable or stall input; stalls are implemented upstream by feeding PC_Out back into PC_In.
- PC_Plus = (PC_Out + PC_INC) mod 2^RegWidth.
  - Wrap-around: with PC_Out = all-ones and PC_INC = 1, PC_Plus = 0.
  - No carry or overflow output.
- PC_In is loaded verbatim: no alignment masking, no saturation.
- Any value of PC_In containing X/Z bits is loaded as-is; the register does no checking.

## Timing

- Load latency: one cycle. The PC_In value present at rising edge N appears on PC_Out right after edge N and holds until edge N+1.
- Reset assertion (RST falling) is asynchronous: PC_Out goes to RESET_VALUE within the same time step, even mid-cycle.
- Reset deassertion (RST rising) takes effect only at the next rising CLK edge.
  - That first edge loads PC_In and sets PC_Valid = 1.
  - Deassertion is expected to be synchronized externally to avoid recovery/removal violations.
- Simultaneous RST low and rising CLK: reset wins; PC_Out = RESET_VALUE.
- Reset asserted mid-operation discards the current PC. There is no save/restore.
- PC_Plus is purely combinational from PC_Out, so it is valid one propagation delay after PC_Out changes.
- Power-up: PC_Out is undefined until the first RST assertion. The system must assert RST at start-up.

## Test plan

- Power-up reset: CLK period 10 ns, RST = 0 from t = 0, PC_In = 0, then PC_In = 59 at 10 ns.
  - Required: PC_Out = 0 and PC_Valid = 0 through 20 ns, with no load despite edges at 5 ns and 15 ns.
- Release and load: RST = 1 at 20 ns with PC_In = 59.
  - Required: at the 25 ns edge, PC_Out = 59, PC_Valid = 1, PC_Plus = 60.
- Asynchronous mid-cycle reset: RST = 0 at 30 ns, between edges.
  - Required: PC_Out = 0 and PC_Valid = 0 immediately at 30 ns, not at the 35 ns edge.
- Reload after reset: PC_In = 93 at 30 ns, RST = 1 at 40 ns.
  - Required: PC_Out stays 0 until the 45 ns edge, then PC_Out = 93.
- Wrap and hold: PC_In = 16'hFFFF loaded.
  - Required: PC_Plus = 0.
  - Then feed PC_Out back into PC_In for 3 edges: PC_Out stays at 16'hFFFF.
- Reset coincident with a clock edge: drive RST low exactly at a rising edge while PC_In = 7.
  - Required: PC_Out = RESET_VALUE, not 7.
